// File: rtl/prog_loader_pit.sv
// Program loader for the simpleton CPU: takes a framed byte stream (length, data, checksum),
// stores it in program memory, then releases the CPU from reset and serves its fetches.
module prog_loader_pit #(
  parameter int         DEPTH    = 128,
  parameter logic [7:0] HLT_BYTE = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [7:0] cpu_addr,
  output logic [7:0] cpu_dout,
  output logic       cpu_rst,
  output logic       busy,
  output logic       err,
  output logic [7:0] prog_len,
  output logic [2:0] state_o
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_ready equals
  // busy and depends only on state, so the host may stall in_valid for any number of cycles.

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    GET_LEN  = 3'b001,
    GET_DATA = 3'b010,
    GET_SUM  = 3'b011,
    RUN      = 3'b100,
    ERR      = 3'b101
  } state_t;

  localparam logic [7:0] LEN_MAX = 8'(DEPTH);

  state_t     state, state_d;
  logic [7:0] pend_len;
  logic [7:0] sum;
  logic [6:0] wr_ptr;
  logic [7:0] mem [0:DEPTH-1];

  logic accept;
  logic start_ok;
  logic len_ok;
  logic last_byte;
  logic sum_ok;

  assign busy      = (state == GET_LEN) || (state == GET_DATA) || (state == GET_SUM);
  assign in_ready  = busy;
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && !busy;
  assign len_ok    = (in_data != 8'd0) && (in_data <= LEN_MAX);
  assign last_byte = ({1'b0, wr_ptr} == (pend_len - 8'd1));
  assign sum_ok    = (in_data == sum);

  assign cpu_rst = (state != RUN);
  assign err     = (state == ERR);
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, RUN, ERR: if (start_ok) state_d = GET_LEN;
      GET_LEN:        if (accept) state_d = len_ok ? GET_DATA : ERR;
      GET_DATA:       if (accept && last_byte) state_d = GET_SUM;
      GET_SUM:        if (accept) state_d = sum_ok ? RUN : ERR;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_len <= 8'd0;
      pend_len <= 8'd0;
      wr_ptr   <= 7'd0;
      sum      <= 8'd0;
    end else if (start_ok) begin
      prog_len <= 8'd0;
      wr_ptr   <= 7'd0;
      sum      <= 8'd0;
    end else if (accept) begin
      case (state)
        GET_LEN: if (len_ok) pend_len <= in_data;
        GET_DATA: begin
          sum <= sum + in_data;
          // Hold the pointer on the final byte so a 128-byte frame never wraps it.
          if (!last_byte) wr_ptr <= wr_ptr + 7'd1;
        end
        GET_SUM: if (sum_ok) prog_len <= pend_len;
        default: ;
      endcase
    end
  end

  // Memory is never cleared; reads are masked by prog_len instead.
  always_ff @(posedge clk) begin
    if (!rst && accept && (state == GET_DATA)) mem[wr_ptr] <= in_data;
  end

  always_comb begin
    cpu_dout = 8'd0;
    if (!cpu_addr[7]) begin
      if ({1'b0, cpu_addr[6:0]} < prog_len) cpu_dout = mem[cpu_addr[6:0]];
      else                                  cpu_dout = HLT_BYTE;
    end
  end

endmodule
